// File: rtl/iob_nco_meter.sv
// iob_nco_meter: period/frequency meter for an asynchronous square wave.
// Averages the input period over 2^navg_i periods. The result is reported as an
// integer part plus a DATA_W-bit fraction, in the NCO period-register format.
//
// Ports:
//   clk_i          system clock
//   cke_i          clock enable; every register, synchronizer included, holds when 0
//   rst_i          synchronous active-high reset
//   enable_i       1 = measure continuously, 0 = go idle and hold results
//   navg_i         log2 of the number of periods per averaging window
//   sig_i          asynchronous signal under measurement (rising edges counted)
//   period_int_o   integer part of the average period, in clk_i cycles
//   period_frac_o  fractional part of the average period (x 2^-DATA_W)
//   valid_o        one-cycle pulse when a new result is written
//   overflow_o     last result saturated (period_int_o forced to all ones)
//   busy_o         state != IDLE
//   min_period_o / max_period_o  single-period extremes since ARM entry
//                  (only when IOB_NCO_METER_MINMAX_EN is defined)
//
// Optional feature macro: IOB_NCO_METER_MINMAX_EN
module iob_nco_meter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 40,
  parameter int unsigned NAVG_W = 3
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [NAVG_W-1:0] navg_i,
  input  logic              sig_i,
  output logic [DATA_W-1:0] period_int_o,
  output logic [DATA_W-1:0] period_frac_o,
  output logic              valid_o,
  output logic              overflow_o,
`ifdef IOB_NCO_METER_MINMAX_EN
  output logic [DATA_W-1:0] min_period_o,
  output logic [DATA_W-1:0] max_period_o,
`endif
  output logic              busy_o
);

  // Edge counter must hold 2^k for the largest k = 2^NAVG_W-1
  localparam int unsigned ECW = 1 << NAVG_W;
  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t            state, state_n;
  logic [1:0]        sync_q;
  logic              sig_d;
  logic              edge_det;
  logic [CNT_W-1:0]  acc;
  logic [ECW-1:0]    edge_cnt;
  logic [NAVG_W-1:0] k_q;

  logic              start_win;
  logic              write_res;
  logic              arm_entry;
  logic              last_edge;
  logic              acc_sat;
  logic [CNT_W-1:0]  t_total;
  logic [DATA_W-1:0] res_int;
  logic [DATA_W-1:0] res_frac;

  // Two-flop synchronizer plus registered rising-edge detect
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      sig_d    <= 1'b0;
      edge_det <= 1'b0;
    end else if (cke_i) begin
      sync_q   <= {sync_q[0], sig_i};
      sig_d    <= sync_q[1];
      edge_det <= sync_q[1] & ~sig_d;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else if (cke_i) begin
      state <= state_n;
    end
  end

  assign last_edge = (edge_cnt + ECW'(1)) == (ECW'(1) << k_q);

  // Next state and control strobes
  always_comb begin
    state_n   = state;
    start_win = 1'b0;
    write_res = 1'b0;
    arm_entry = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_n   = ARM;
          arm_entry = 1'b1;
        end
      end
      ARM: begin
        if (!enable_i) begin
          state_n = IDLE;
        end else if (edge_det) begin
          state_n   = MEASURE;
          start_win = 1'b1;
        end
      end
      MEASURE: begin
        if (!enable_i) begin
          state_n = IDLE;
        end else if (edge_det && last_edge) begin
          // Terminating edge also opens the next window
          write_res = 1'b1;
          start_win = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // acc is cleared on the opening edge, so the window total is acc+1 at the closing edge
  assign acc_sat  = (acc == ACC_MAX);
  assign t_total  = acc_sat ? acc : acc + CNT_W'(1);
  assign res_int  = DATA_W'(t_total >> k_q);
  assign res_frac = DATA_W'({t_total, DATA_W'(0)} >> k_q);

  // Window accumulator, edge counter and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc           <= '0;
      edge_cnt      <= '0;
      k_q           <= '0;
      period_int_o  <= '0;
      period_frac_o <= '0;
      valid_o       <= 1'b0;
      overflow_o    <= 1'b0;
      busy_o        <= 1'b0;
    end else if (cke_i) begin
      valid_o <= write_res;
      busy_o  <= (state_n != IDLE);
      if (start_win) begin
        acc      <= '0;
        edge_cnt <= '0;
        k_q      <= navg_i;
      end else if (state == MEASURE) begin
        if (!acc_sat) acc <= acc + CNT_W'(1);
        if (edge_det) edge_cnt <= edge_cnt + ECW'(1);
      end
      if (write_res) begin
        period_int_o  <= acc_sat ? '1 : res_int;
        period_frac_o <= res_frac;
        overflow_o    <= acc_sat;
      end
    end
  end

`ifdef IOB_NCO_METER_MINMAX_EN
  logic [DATA_W-1:0] pcnt;
  logic [DATA_W-1:0] single_p;
  logic              meas_edge;

  assign single_p  = (pcnt == '1) ? pcnt : pcnt + DATA_W'(1);
  assign meas_edge = (state == MEASURE) && enable_i && edge_det;

  // Single-period extremes; pcnt counts cycles since the previous edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt         <= '0;
      min_period_o <= '0;
      max_period_o <= '0;
    end else if (cke_i) begin
      if (edge_det && (state != IDLE)) begin
        pcnt <= '0;
      end else if ((state == MEASURE) && (pcnt != '1)) begin
        pcnt <= pcnt + DATA_W'(1);
      end
      if (arm_entry) begin
        min_period_o <= '1;
        max_period_o <= '0;
      end else if (meas_edge) begin
        if (single_p < min_period_o) min_period_o <= single_p;
        if (single_p > max_period_o) max_period_o <= single_p;
      end
    end
  end
`endif

endmodule

// File: doc/iob_nco_meter.md
Name: iob_nco_meter

Overview:
Period/frequency meter, the measuring counterpart of the NCO. Samples an asynchronous square wave (e.g. an NCO clk_out) in the system clock domain and measures its average period over 2^k input periods. Reports the result as integer and 32-bit fractional parts, in the same format the NCO period registers take. Sits beside the NCO for closed-loop calibration and self-test.

Parameters:
DATA_W, 32, width of period_int_o and period_frac_o
CNT_W, 40, width of the cycle accumulator; must be >= DATA_W + 2^NAVG_W - 1
NAVG_W, 3, width of navg_i; averaging over 2^navg_i periods, navg_i in 0..2^NAVG_W-1

Ports:
clk_i  in  1  system clock
cke_i  in  1  clock enable; when 0 all state, synchronizer flops included, holds
rst_i  in  1  reset; synchronous, active-high
enable_i  in  1  1 = measure continuously; 0 = return to IDLE and hold results
navg_i  in  NAVG_W  log2 of the number of periods per window
sig_i  in  1  asynchronous signal under measurement
period_int_o  out  DATA_W  integer part of the average period, in clk_i cycles
period_frac_o  out  DATA_W  fractional part of the average period (x 2^-32)
valid_o  out  1  one-cycle pulse when a new result is written
overflow_o  out  1  the last result saturated
busy_o  out  1  1 when state != IDLE

Behaviour:
- Interface: one clock (clk_i). Reset rst_i is synchronous and active-high. Every register is updated only when cke_i=1.
- Reset: state=IDLE. period_int_o, period_frac_o, valid_o, overflow_o, busy_o and the accumulators are all 0.
- Input path: sig_i feeds a 2-flop synchronizer, then an edge register.
- A rising edge is detected (edge_det) 3 enabled cycles after sig_i rises. Only rising edges count.
- FSM IDLE: enable_i=1 moves to ARM.
- FSM ARM: waits for edge_det. On edge_det it latches k=navg_i, clears acc and the edge counter, and moves to MEASURE.
- FSM MEASURE:
  - acc increments every cycle; the window total equals t_last_edge - t_first_edge in clk_i cycles.
  - Each edge_det increments the edge counter.
  - When the edge counter reaches 2^k, the result is written.
  - The same edge starts the next window: acc restarts, k is re-latched from navg_i, and the state stays in MEASURE.
- Result write, with T = window total:
  - period_int_o = T[k+DATA_W-1:k]
  - period_frac_o = {T[k-1:0], zeros}, i.e. T/2^k in Q32.32
  - k=0 gives period_frac_o=0.
- Result timing: valid_o pulses in the cycle after the terminating edge_det. Outputs are registered and hold until the next write.
- Overflow: acc saturates at 2^CNT_W-1. If saturation occurred within the window, the write sets overflow_o=1 and forces period_int_o to all ones. Otherwise the write clears overflow_o.
- enable_i=0 in any state: next state is IDLE. The partial window is discarded, results are held, and no valid_o pulse is generated.
- navg_i changes mid-window: ignored until the next window start.
- rst_i mid-window: takes priority over everything and restores reset values next cycle.
- sig_i constant: no result is ever produced. Once acc saturates it stays saturated until an edge arrives.

Optional Feature:
IOB_NCO_METER_MINMAX_EN
- Defined:
  - Adds outputs min_period_o and max_period_o, each DATA_W wide.
  - These track the single-period cycle count (cycles between consecutive edges) across all windows since entering ARM.
  - On ARM entry they reset to min=all ones, max=0.
  - They update in the cycle after each edge_det in MEASURE.
  - Single-period counts saturate at 2^DATA_W-1.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Square wave period 10 cycles, navg_i=0, enable_i=1 -> first valid_o after 2nd detected edge; period_int_o=10, period_frac_o=0, overflow_o=0; valid_o repeats every 10 cycles.
- Periods alternating 18/19 cycles, navg_i=1 -> period_int_o=18, period_frac_o=0x80000000. With MINMAX_EN: min=18, max=19.
- Periods 4,5,5,5, navg_i=2 -> period_int_o=4, period_frac_o=0xC0000000; the next window starts on the terminating edge with no lost period.
- sig_i held low with CNT_W overridden to 12 -> no valid_o. A single later edge pair more than 4095 cycles apart -> overflow_o=1, period_int_o=all ones. A following normal window clears overflow_o.
- enable_i dropped mid-window -> no valid_o pulse; results hold the last value; busy_o=0 next cycle. rst_i mid-window -> all outputs 0 next cycle.
- cke_i low for 5 cycles during a 10-cycle-period measurement -> state frozen; no edges lost or duplicated after cke_i returns high.
